ldm_stm_seq: RTL and testbench

Block-transfer sequencer for ARM LDM/STM instructions. It drives the register file from the datapath side: on STM it walks the register list through the read-port select and streams each value to memory; on LDM it fetches words from memory and issues one register-file write per listed register through the write-port decoder select and load enable. It sits between the control unit, the 16×32 register file and the memory interface, and also reports the base-register writeback value.

---
 rtl/ldm_stm_seq.sv | 168 ++++++++++++++++
 tb/tb_ldm_stm_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldm_stm_seq.sv
// LDM/STM block-transfer sequencer: walks the register list against memory,
// one memory beat per register, and reports the base writeback value.
//   state | meaning
//   IDLE  | waiting for start
//   SETUP | count listed registers, compute lowest and writeback addresses
//   XFER  | memory beat for the current register (holds while mem_ready=0)
//   WB    | LDM register-file write of the captured word
//   DONE  | one-cycle completion pulse
module ldm_stm_seq #(
  parameter int DW   = 32,
  parameter int NREG = 16
) (
  input  logic                     Clk,
  input  logic                     Clr,
  input  logic                     start,
  input  logic                     is_load,
  input  logic                     pre,
  input  logic                     up,
  input  logic [NREG-1:0]          reg_list,
  input  logic [DW-1:0]            base_addr,
  input  logic [DW-1:0]            rf_rdata,
  input  logic [DW-1:0]            mem_rdata,
  input  logic                     mem_ready,
  output logic [$clog2(NREG)-1:0]  rf_sel,
  output logic                     rf_ld,
  output logic [DW-1:0]            rf_wdata,
  output logic                     mem_en,
  output logic                     mem_rw,
  output logic [DW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  output logic [DW-1:0]            wb_addr,
  output logic                     busy,
  output logic                     done
);
  localparam int SW = $clog2(NREG);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_WB, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [NREG-1:0] mask_q, mask_d, mask_clr;
  logic            is_load_q, is_load_d;
  logic            pre_q, pre_d;
  logic            up_q, up_d;
  logic [DW-1:0]   base_q, base_d;
  logic [DW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wb_q, wb_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   span;
  logic [SW-1:0]   sel_q, sel_d;

  function automatic logic [SW:0] popcnt(input logic [NREG-1:0] m);
    logic [SW:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) c = c + {{SW{1'b0}}, m[i]};
    return c;
  endfunction

  function automatic logic [SW-1:0] lowest(input logic [NREG-1:0] m);
    logic [SW-1:0] s;
    s = '0;
    for (int i = NREG - 1; i >= 0; i--) if (m[i]) s = SW'(i);
    return s;
  endfunction

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      is_load_q <= 1'b0;
      pre_q     <= 1'b0;
      up_q      <= 1'b0;
      base_q    <= '0;
      addr_q    <= '0;
      wb_q      <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      is_load_q <= is_load_d;
      pre_q     <= pre_d;
      up_q      <= up_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      wb_q      <= wb_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    is_load_d = is_load_q;
    pre_d     = pre_q;
    up_d      = up_q;
    base_d    = base_q;
    addr_d    = addr_q;
    wb_d      = wb_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    span      = {{(DW-SW-3){1'b0}}, popcnt(mask_q), 2'b00};
    mask_clr  = mask_q & ~(NREG'(1) << sel_q);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SETUP;
          mask_d    = reg_list;
          is_load_d = is_load;
          pre_d     = pre;
          up_d      = up;
          base_d    = base_addr;
        end
      end
      S_SETUP: begin
        wb_d = up_q ? base_q + span : base_q - span;
        // Lowest register always lands on the lowest address of the block.
        if (pre_q) addr_d = up_q ? base_q + DW'(4) : base_q - span;
        else       addr_d = up_q ? base_q : base_q - span + DW'(4);
        if (mask_q == '0) begin
          state_d = S_DONE;
        end else begin
          sel_d   = lowest(mask_q);
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (mem_ready) begin
          mask_d = mask_clr;
          addr_d = addr_q + DW'(4);
          if (is_load_q) begin
            wdata_d = mem_rdata;
            state_d = S_WB;
          end else if (mask_clr == '0) begin
            state_d = S_DONE;
          end else begin
            sel_d = lowest(mask_clr);
          end
        end
      end
      S_WB: begin
        if (mask_q == '0) begin
          state_d = S_DONE;
        end else begin
          sel_d   = lowest(mask_q);
          state_d = S_XFER;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_en = (state_q == S_XFER);
    mem_rw = (state_q == S_XFER) & is_load_q;
    rf_ld  = (state_q == S_WB);
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE);
  end

  assign rf_sel    = sel_q;
  assign rf_wdata  = wdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = rf_rdata;
  assign wb_addr   = wb_q;

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Scoreboard bench for ldm_stm_seq: an abstract transfer-list model fills
// expectation queues; a monitor checks every memory beat, register write and done.
module tb_ldm_stm_seq;
  logic        Clk = 1'b0;
  logic        Clr = 1'b1;
  logic        start = 1'b0, is_load = 1'b0, pre = 1'b0, up = 1'b0;
  logic [15:0] reg_list = '0;
  logic [31:0] base_addr = '0, rf_rdata, mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [3:0]  rf_sel;
  logic        rf_ld, mem_en, mem_rw, busy, done;
  logic [31:0] rf_wdata, mem_addr, mem_wdata, wb_addr;

  ldm_stm_seq #(.DW(32), .NREG(16)) dut (
    .Clk(Clk), .Clr(Clr), .start(start), .is_load(is_load), .pre(pre), .up(up),
    .reg_list(reg_list), .base_addr(base_addr), .rf_rdata(rf_rdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .rf_sel(rf_sel), .rf_ld(rf_ld),
    .rf_wdata(rf_wdata), .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .wb_addr(wb_addr), .busy(busy), .done(done)
  );

  typedef struct { logic [31:0] addr; logic rw; logic [3:0] sel; logic [31:0] wdata; int cyc; } mem_t;
  typedef struct { logic [3:0] sel; logic [31:0] data; int cyc; } rfw_t;
  typedef struct { logic [31:0] wb; int cyc; } done_t;

  mem_t        mq[$];
  rfw_t        rfq[$];
  done_t       dq[$];
  mem_t        me;
  rfw_t        re;
  done_t       de;
  logic [31:0] rdata_q[$];
  int          waits_q[$];
  logic [31:0] user_data[$];
  logic [31:0] regs [16];
  int          checks = 0, errors = 0, cyc = 0, wait_left = -1;
  bit          prev_done = 1'b0;
  bit          seen;

  always #5 Clk = ~Clk;
  assign rf_rdata = regs[rf_sel];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  // Memory responder: drives ready/data just after each edge.
  initial forever begin
    @(posedge Clk);
    #1;
    if (Clr) begin
      mem_ready = 1'b0;
      wait_left = -1;
    end else if (mem_en) begin
      if (wait_left < 0) wait_left = (waits_q.size() > 0) ? waits_q.pop_front() : 0;
      if (wait_left > 0) begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        wait_left--;
      end else begin
        mem_ready = 1'b1;
        mem_rdata = (rdata_q.size() > 0) ? rdata_q.pop_front() : $urandom;
        wait_left = -1;
      end
    end else begin
      mem_ready = 1'($urandom);
      mem_rdata = $urandom;
    end
  end

  // Monitor: checks whatever the DUT presents in each cycle.
  initial forever begin
    @(negedge Clk);
    if (Clr) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("busy_after_done", 32'(busy), 32'd0);
      if (mem_en) begin
        chk("busy_in_xfer", 32'(busy), 32'd1);
        if (mq.size() == 0) begin
          chk("mem_en_unexpected", 32'(mem_en), 32'd0);
        end else begin
          me = mq[0];
          chk("mem_addr", mem_addr, me.addr);
          chk("mem_rw", 32'(mem_rw), 32'(me.rw));
          chk("rf_sel_xfer", 32'(rf_sel), 32'(me.sel));
          if (!me.rw) chk("mem_wdata", mem_wdata, me.wdata);
          if (mem_ready) begin
            chk("xfer_cycle", 32'(cyc), 32'(me.cyc));
            mq.delete(0);
          end
        end
      end
      if (rf_ld) begin
        if (rfq.size() == 0) begin
          chk("rf_ld_unexpected", 32'(rf_ld), 32'd0);
        end else begin
          re = rfq.pop_front();
          chk("rf_sel_wb", 32'(rf_sel), 32'(re.sel));
          chk("rf_wdata", rf_wdata, re.data);
          chk("wb_cycle", 32'(cyc), 32'(re.cyc));
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          chk("done_unexpected", 32'(done), 32'd0);
        end else begin
          de = dq.pop_front();
          chk("wb_addr", wb_addr, de.wb);
          chk("done_cycle", 32'(cyc), 32'(de.cyc));
        end
      end
      prev_done = done;
    end
  end

  // Reference model: transfer list derived from the list bits and addressing mode.
  task automatic issue(input bit ld, input bit p, input bit u, input logic [15:0] list,
                       input logic [31:0] base, input int wmode);
    int          idx[$];
    int          n, t, w;
    logic [31:0] lo, wb, n4, d;
    @(negedge Clk);
    for (int i = 0; i < 16; i++) if (list[i]) idx.push_back(i);
    n  = idx.size();
    n4 = 32'(4 * n);
    if (p) lo = u ? base + 32'd4 : base - n4;
    else   lo = u ? base : base - n4 + 32'd4;
    wb = u ? base + n4 : base - n4;
    t  = cyc + 2;
    for (int j = 0; j < n; j++) begin
      w = (wmode < 0) ? int'($urandom_range(0, 2)) : wmode;
      waits_q.push_back(w);
      t += w;
      mq.push_back('{addr: lo + 32'(4 * j), rw: ld, sel: 4'(idx[j]), wdata: regs[idx[j]], cyc: t});
      if (ld) begin
        d = (user_data.size() > 0) ? user_data.pop_front() : $urandom;
        rdata_q.push_back(d);
        rfq.push_back('{sel: 4'(idx[j]), data: d, cyc: t + 1});
        t += 2;
      end else begin
        t += 1;
      end
    end
    dq.push_back('{wb: wb, cyc: t});
    is_load = ld; pre = p; up = u; reg_list = list; base_addr = base; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    is_load = 1'($urandom); pre = 1'($urandom); up = 1'($urandom);
    reg_list = 16'($urandom); base_addr = $urandom;
  endtask

  task automatic finish_op(input bit poke_busy, input bit poke_done);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      start = 1'b0;
      if (done) begin
        got = 1'b1;
        if (poke_done) begin
          start = 1'b1; reg_list = 16'hFFFF; base_addr = $urandom; is_load = 1'($urandom);
        end
        break;
      end
      if (poke_busy && i == 0) begin
        start = 1'b1; reg_list = 16'hFFFF; base_addr = $urandom; is_load = 1'($urandom);
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 400 cycles");
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    // Reset held with random inputs.
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      start = 1'($urandom); is_load = 1'($urandom); pre = 1'($urandom); up = 1'($urandom);
      reg_list = 16'($urandom); base_addr = $urandom;
      chk("rst_rf_sel", 32'(rf_sel), 32'd0);
      chk("rst_rf_ld", 32'(rf_ld), 32'd0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_rw", 32'(mem_rw), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_wb_addr", wb_addr, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
    end
    start = 1'b0;
    Clr = 1'b0;

    issue(1'b0, 1'b0, 1'b1, 16'h0015, 32'h100, 0);
    finish_op(1'b0, 1'b0);
    user_data.push_back(32'hAAAA0001);
    user_data.push_back(32'hBBBB000F);
    issue(1'b1, 1'b1, 1'b0, 16'h8002, 32'h200, 0);
    finish_op(1'b0, 1'b0);
    issue(1'b0, 1'b1, 1'b1, 16'h0001, 32'h0, 3);
    finish_op(1'b0, 1'b0);
    issue(1'b0, 1'b0, 1'b1, 16'h0000, 32'h40, 0);
    finish_op(1'b0, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 16'hFFFF, 32'h4, 0);
    finish_op(1'b1, 1'b1);
    issue(1'b0, 1'b0, 1'b1, 16'($urandom), $urandom, 0);
    finish_op(1'b0, 1'b0);

    // Abort an LDM in its second XFER.
    issue(1'b1, 1'b0, 1'b1, 16'hFFFF, $urandom, 2);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge Clk);
      if (rf_ld) seen = 1'b1;
    end
    for (int i = 0; i < 60 && seen; i++) begin
      @(negedge Clk);
      if (mem_en) seen = 1'b0;
    end
    chk("abort_reached_xfer", 32'(mem_en), 32'd1);
    #2;
    Clr = 1'b1;
    mq.delete(); rfq.delete(); dq.delete(); rdata_q.delete(); waits_q.delete();
    #1;
    chk("abort_async_mem_en", 32'(mem_en), 32'd0);
    chk("abort_async_busy", 32'(busy), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      chk("abort_rf_ld", 32'(rf_ld), 32'd0);
      chk("abort_mem_en", 32'(mem_en), 32'd0);
    end

    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    for (int k = 0; k < 40; k++) begin
      logic [15:0] lst;
      int sel;
      bit pd;
      sel = int'($urandom_range(0, 4));
      case (sel)
        0:       lst = 16'h0000;
        1:       lst = 16'(1 << $urandom_range(0, 15));
        2:       lst = 16'($urandom) & 16'($urandom);
        default: lst = 16'($urandom);
      endcase
      pd = (k != 39) && ($urandom_range(0, 2) == 0);
      issue(1'($urandom), 1'($urandom), 1'($urandom), lst, $urandom,
            ($urandom_range(0, 1) == 1) ? -1 : 0);
      finish_op(1'($urandom), pd);
      if (!pd) repeat (int'($urandom_range(0, 2))) @(negedge Clk);
    end

    repeat (5) @(negedge Clk);
    chk("mq_drained", 32'(mq.size()), 32'd0);
    chk("rfq_drained", 32'(rfq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
